// File: rtl/tdc_sample_ctrl.sv
// Sequencer for a carry-chain TDC. It launches an edge into the chain, captures the
// chain after a programmable delay, and accumulates the sum, min, max and overflow of the popcounts over a burst.
module tdc_sample_ctrl #(
  parameter int N     = 128,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [7:0]       num_samples,
  input  logic [3:0]       launch_dly,
  input  logic [N-1:0]     chain_regout,
  output logic             chain_carryin,
  output logic             chain_enable,
  output logic             chain_clear,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic [7:0]       res_min,
  output logic [7:0]       res_max,
  output logic             overflow
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LAUNCH, S_WAIT, S_CAPT, S_SETTLE, S_DECODE, S_ACC, S_DONE
  } state_t;

  localparam logic [7:0] FULL_POP = 8'(N);

  state_t         state, state_next;
  logic [7:0]     remaining;
  logic [3:0]     dly_q;
  logic [3:0]     dly_cnt;
  logic [7:0]     pop;
  logic [7:0]     pop_next;
  logic [ACC_W:0] sum_wide;

  // NOTE: clear has priority over every other input. A start that arrives in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (clear) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default first, so the case arms never infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_CLR;
      S_CLR:    state_next = S_LAUNCH;
      S_LAUNCH: state_next = (dly_q == 4'd0) ? S_CAPT : S_WAIT;
      S_WAIT:   if (dly_cnt == 4'd1) state_next = S_CAPT;
      S_CAPT:   state_next = S_SETTLE;
      S_SETTLE: state_next = S_DECODE;
      S_DECODE: state_next = S_ACC;
      S_ACC:    state_next = (remaining == 8'd1) ? S_DONE : S_CLR;
      S_DONE:   if (res_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from state_next and then registered, so each one is glitch-free
  // and lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (clear) begin
      chain_carryin <= 1'b0;
      chain_enable  <= 1'b0;
      chain_clear   <= 1'b1;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
    end else begin
      chain_carryin <= (state_next == S_LAUNCH) || (state_next == S_WAIT) ||
                       (state_next == S_CAPT);
      chain_enable  <= (state_next == S_CAPT);
      chain_clear   <= (state_next == S_CLR);
      busy          <= (state_next != S_IDLE);
      res_valid     <= (state_next == S_DONE);
    end
  end

  always_comb begin
    pop_next = 8'd0;
    for (int i = 0; i < N; i++) pop_next = pop_next + 8'(chain_regout[i]);
  end

  assign sum_wide = {1'b0, res_sum} + (ACC_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (clear) begin
      remaining <= 8'd0;
      dly_q     <= 4'd0;
      dly_cnt   <= 4'd0;
      pop       <= 8'd0;
      res_sum   <= '0;
      res_min   <= 8'd0;
      res_max   <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          remaining <= (num_samples == 8'd0) ? 8'd1 : num_samples;
          dly_q     <= launch_dly;
          res_sum   <= '0;
          res_min   <= 8'hFF;
          res_max   <= 8'd0;
          overflow  <= 1'b0;
        end
        S_LAUNCH: dly_cnt <= dly_q;
        S_WAIT:   dly_cnt <= dly_cnt - 4'd1;
        S_DECODE: pop <= pop_next;
        S_ACC: begin
          // A carry out of the top bit means the sum has saturated at all-ones.
          res_sum   <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
          if (pop < res_min) res_min <= pop;
          if (pop > res_max) res_max <= pop;
          if (pop == FULL_POP) overflow <= 1'b1;
          remaining <= remaining - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_sample_ctrl.sv
// Directed bench for tdc_sample_ctrl. A behavioural chain model returns a thermometer
// word with a chosen popcount on each capture pulse.
module tb_tdc_sample_ctrl;
  localparam int N = 128;

  logic         clk = 1'b0;
  logic         clear, start, res_ready;
  logic [7:0]   num_samples;
  logic [3:0]   launch_dly;
  logic [N-1:0] chain_regout = '0;

  logic         chain_carryin, chain_enable, chain_clear, busy, res_valid, overflow;
  logic [15:0]  res_sum;
  logic [7:0]   res_min, res_max;

  logic         sat_carryin, sat_enable, sat_clear, sat_busy, sat_valid, sat_overflow;
  logic [7:0]   sat_sum, sat_min, sat_max;

  int total = 0;
  int bad   = 0;
  int pop_list [0:7];
  int pop_idx  = 0;
  int en_cnt   = 0;
  int en_wide  = 0;
  int en_clr   = 0;
  logic prev_en = 1'b0;
  logic [4:0] trace_exp [0:8];
  int cyc;

  always #5 clk = ~clk;

  tdc_sample_ctrl #(.N(N), .ACC_W(16)) u_dut (
    .clk(clk), .clear(clear), .start(start), .num_samples(num_samples),
    .launch_dly(launch_dly), .chain_regout(chain_regout),
    .chain_carryin(chain_carryin), .chain_enable(chain_enable), .chain_clear(chain_clear),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_min(res_min), .res_max(res_max), .overflow(overflow)
  );

  tdc_sample_ctrl #(.N(N), .ACC_W(8)) u_sat (
    .clk(clk), .clear(clear), .start(start), .num_samples(num_samples),
    .launch_dly(launch_dly), .chain_regout(chain_regout),
    .chain_carryin(sat_carryin), .chain_enable(sat_enable), .chain_clear(sat_clear),
    .busy(sat_busy), .res_valid(sat_valid), .res_ready(res_ready), .res_sum(sat_sum),
    .res_min(sat_min), .res_max(sat_max), .overflow(sat_overflow)
  );

  function automatic logic [N-1:0] therm(input int p);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (i < p);
    return v;
  endfunction

  // Chain model plus capture-pulse bookkeeping.
  always @(posedge clk) begin
    if (!busy) begin
      pop_idx <= 0;
      en_cnt  <= 0;
    end else if (chain_enable) begin
      chain_regout <= therm(pop_list[pop_idx % 8]);
      pop_idx      <= pop_idx + 1;
      en_cnt       <= en_cnt + 1;
    end
    if (chain_enable && prev_en)     en_wide <= en_wide + 1;
    if (chain_enable && chain_clear) en_clr  <= en_clr + 1;
    prev_en <= chain_enable;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, then counts cycles from the accepted start until res_valid rises.
  task automatic run_burst(input int ns, input int dly, output int c);
    num_samples = 8'(ns);
    launch_dly  = 4'(dly);
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (!res_valid && c < 2000) begin
      step();
      c++;
    end
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_valid_low"}, 32'(res_valid), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; res_ready = 1'b0;
    num_samples = 8'd1; launch_dly = 4'd0;
    trace_exp = '{5'b00110, 5'b10010, 5'b10010, 5'b10010, 5'b11010,
                  5'b00010, 5'b00010, 5'b00010, 5'b00011};

    step(); step();
    check("rst_carryin", 32'(chain_carryin), 0);
    check("rst_enable", 32'(chain_enable), 0);
    check("rst_chain_clear", 32'(chain_clear), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_sum", 32'(res_sum), 0);
    check("rst_min", 32'(res_min), 0);
    check("rst_max", 32'(res_max), 0);
    check("rst_ovf", 32'(overflow), 0);
    clear = 1'b0;
    step();
    check("rel_chain_clear", 32'(chain_clear), 0);
    check("rel_busy", 32'(busy), 0);

    // Single sample: 37 ones, no launch delay.
    pop_list[0] = 37;
    run_burst(1, 0, cyc);
    check("single_latency", 32'(cyc), 6);
    check("single_sum", 32'(res_sum), 37);
    check("single_min", 32'(res_min), 37);
    check("single_max", 32'(res_max), 37);
    check("single_ovf", 32'(overflow), 0);
    check("single_en_cnt", 32'(en_cnt), 1);
    check("single_sat_sum", 32'(sat_sum), 37);
    handshake("single_hs");
    check("single_kept_sum", 32'(res_sum), 37);

    // Cycle-by-cycle trace, launch_dly=2: {carryin, enable, chain_clear, busy, valid}.
    pop_list[0] = 64;
    num_samples = 8'd1; launch_dly = 4'd2;
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      start = 1'b0;
      check($sformatf("trace_%0d", i),
            32'({chain_carryin, chain_enable, chain_clear, busy, res_valid}), 32'(trace_exp[i]));
    end
    check("trace_sum", 32'(res_sum), 64);
    handshake("trace_hs");

    // Burst of four samples with launch_dly=3.
    pop_list[0] = 10; pop_list[1] = 20; pop_list[2] = 5; pop_list[3] = 40;
    run_burst(4, 3, cyc);
    check("burst_latency", 32'(cyc), 36);
    check("burst_sum", 32'(res_sum), 75);
    check("burst_min", 32'(res_min), 5);
    check("burst_max", 32'(res_max), 40);
    check("burst_ovf", 32'(overflow), 0);
    check("burst_en_cnt", 32'(en_cnt), 4);

    // Backpressure: hold off res_ready while start is pulsed in DONE.
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      step();
      check("bp_valid", 32'(res_valid), 1);
      check("bp_busy", 32'(busy), 1);
      check("bp_sum", 32'(res_sum), 75);
    end
    res_ready = 1'b1;
    step();
    start = 1'b0; res_ready = 1'b0;
    check("bp_hs_valid", 32'(res_valid), 0);
    check("bp_hs_idle", 32'(busy), 0);
    step();
    check("bp_start_ignored", 32'(busy), 0);
    check("bp_kept_sum", 32'(res_sum), 75);

    // Saturation in the 8-bit accumulator instance.
    pop_list[0] = 128; pop_list[1] = 128; pop_list[2] = 128;
    run_burst(3, 0, cyc);
    check("sat_latency", 32'(cyc), 18);
    check("sat_sum8", 32'(sat_sum), 255);
    check("sat_ovf8", 32'(sat_overflow), 1);
    check("sat_max8", 32'(sat_max), 128);
    check("sat_sum16", 32'(res_sum), 384);
    check("sat_ovf16", 32'(overflow), 1);
    handshake("sat_hs");

    // num_samples=0 takes exactly one sample.
    pop_list[0] = 50; pop_list[1] = 60;
    run_burst(0, 0, cyc);
    check("zero_latency", 32'(cyc), 6);
    check("zero_sum", 32'(res_sum), 50);
    check("zero_en_cnt", 32'(en_cnt), 1);
    handshake("zero_hs");

    // Clear during the WAIT of sample 2, then a start coincident with clear.
    pop_list[0] = 7; pop_list[1] = 8; pop_list[2] = 9;
    num_samples = 8'd3; launch_dly = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    check("mid_in_wait_carryin", 32'(chain_carryin), 1);
    check("mid_in_wait_sum", 32'(res_sum), 7);
    clear = 1'b1;
    step();
    check("mid_clr_busy", 32'(busy), 0);
    check("mid_clr_carryin", 32'(chain_carryin), 0);
    check("mid_clr_chain_clear", 32'(chain_clear), 1);
    check("mid_clr_sum", 32'(res_sum), 0);
    check("mid_clr_min", 32'(res_min), 0);
    start = 1'b1;
    step();
    check("clr_start_busy", 32'(busy), 0);
    clear = 1'b0; start = 1'b0;
    step();
    check("clr_start_ignored", 32'(busy), 0);
    check("mid_rel_chain_clear", 32'(chain_clear), 0);

    pop_list[0] = 11; pop_list[1] = 22;
    run_burst(2, 1, cyc);
    check("after_clr_latency", 32'(cyc), 14);
    check("after_clr_sum", 32'(res_sum), 33);
    check("after_clr_min", 32'(res_min), 11);
    check("after_clr_max", 32'(res_max), 22);
    check("after_clr_en_cnt", 32'(en_cnt), 2);
    handshake("after_clr_hs");

    check("enable_single_cycle", 32'(en_wide), 0);
    check("enable_clear_exclusive", 32'(en_clr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_sample_ctrl.md
TDC_SAMPLE_CTRL -- requirements
Module: tdc_sample_ctrl

Interface
REQ-001 Parameter N, default 128: carry-chain length in taps.
REQ-002 Parameter ACC_W, default 16: accumulator and result width.
REQ-003 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 Port clear, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: one-cycle request to begin a measurement burst; sampled only in IDLE.
REQ-006 Port num_samples, input, 8: samples per burst; 0 is treated as 1; latched on accepted start.
REQ-007 Port launch_dly, input, 4: WAIT cycles between launch and capture; latched on accepted start.
REQ-008 Port chain_regout, input, N: captured chain register word.
REQ-009 Port chain_carryin, output, 1: edge launched into the chain input.
REQ-010 Port chain_enable, output, 1: capture enable to the chain registers.
REQ-011 Port chain_clear, output, 1: synchronous clear to the chain registers.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port res_valid, output, 1: result available; held until accepted.
REQ-014 Port res_ready, input, 1: consumer accepts the result when res_valid and res_ready are both high.
REQ-015 Port res_sum, output, ACC_W: sum of per-sample popcounts over the burst.
REQ-016 Port res_min / res_max, outputs, 8 each: minimum and maximum per-sample popcount in the burst.
REQ-017 Port overflow, output, 1: high if any sample in the burst had popcount == N.

Function
REQ-018 States: IDLE, CLR, LAUNCH, WAIT, CAPT, SETTLE, DECODE, ACC, DONE; all outputs are registered.
REQ-019 IDLE: start=1 latches the inputs, zeroes the accumulator, sets min=8'hFF, max=0 and overflow=0, then moves to CLR.
REQ-020 CLR: chain_clear=1 and chain_carryin=0 for one cycle, then LAUNCH.
REQ-021 LAUNCH: chain_carryin=1 for one cycle and loads the delay counter with launch_dly; the next state is WAIT, or CAPT if launch_dly=0.
REQ-022 WAIT: chain_carryin=1; the counter decrements each cycle; the block stays exactly launch_dly cycles, then moves to CAPT.
REQ-023 CAPT: chain_carryin=1 and chain_enable=1 for exactly one cycle, then SETTLE.
REQ-024 SETTLE: chain_carryin=0 for one cycle, then DECODE; chain_regout is valid from this state onward.
REQ-025 DECODE: registers the popcount of chain_regout (0..N, 8 bits), then ACC.
REQ-026 ACC: adds the popcount to the accumulator, which saturates at all-ones; updates min and max; sets overflow if popcount == N; decrements the remaining-sample count.
REQ-027 From ACC, the block goes to CLR if samples remain, otherwise to DONE.
REQ-028 Sample period is 6+launch_dly cycles; the burst takes num_samples x (6+launch_dly) cycles from the accepted start to res_valid.
REQ-029 DONE: res_valid=1 and results are stable; on res_valid&res_ready, the next cycle has res_valid=0 and state IDLE.
REQ-030 Results stay readable after the handshake, until the next accepted start.
REQ-031 A start asserted outside IDLE is ignored, including during DONE and in the handshake cycle.
REQ-032 chain_carryin is low in IDLE, CLR, SETTLE, DECODE, ACC and DONE.
REQ-033 chain_enable and chain_clear are never high in the same cycle.

Reset
REQ-034 clear=1 at any clock edge, including mid-burst or in DONE, forces IDLE.
REQ-035 While clear=1, the outputs are chain_carryin=0, chain_enable=0, chain_clear=1, busy=0, res_valid=0, res_sum=0, res_min=0, res_max=0 and overflow=0.
REQ-036 On the cycle after clear deasserts, chain_clear=0.
REQ-037 A start coincident with clear is ignored.

Verification
REQ-038 Single sample: num_samples=1, launch_dly=0, regout with 37 ones -> res_valid 6 cycles after start, res_sum=37, min=max=37, overflow=0.
REQ-039 Burst: num_samples=4, launch_dly=3, popcounts 10,20,5,40 -> res_sum=75, min=5, max=40; res_valid at cycle 36; exactly 4 chain_enable pulses, each 1 cycle.
REQ-040 Backpressure and start: res_ready low for 10 cycles in DONE with start pulsed -> outputs stable, start ignored; res_ready=1 -> IDLE next cycle.
REQ-041 Saturation: ACC_W=8, num_samples=3, popcount=128 each -> res_sum=255, overflow=1, max=128.
REQ-042 Reset mid-burst: clear during WAIT of sample 2 -> IDLE the next cycle with all outputs at reset values; a following start runs a full, correct burst.
REQ-043 num_samples=0 -> exactly one sample is taken.
